// File: rtl/field_arbiter_if.sv
// field_arbiter_if
//   Groups the requester, output and status signals of field_arbiter.
//   master : requester/downstream side (drives strobes, fields, clear, ready)
//   slave  : the arbiter itself
// Signals
//   req_valid  [N_REQ]            per-requester capture strobe
//   req_field  [N_REQ*FIELD_SIZE] flattened fields, requester i at [i*FIELD_SIZE +: FIELD_SIZE]
//   clear                         packet-start flush of pending slots
//   out_valid/out_field/out_tag   granted output word
//   out_ready                     downstream accept
//   overflow   [N_REQ]            one-cycle pulse per dropped strobe
//   busy                          any slot pending or output occupied
//   drop_count [16]               dropped-strobe total (zero unless counter built in)
interface field_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int FIELD_SIZE = 16
);
  localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*FIELD_SIZE-1:0] req_field;
  logic                        clear;
  logic                        out_valid;
  logic [FIELD_SIZE-1:0]       out_field;
  logic [TAG_W-1:0]            out_tag;
  logic                        out_ready;
  logic [N_REQ-1:0]            overflow;
  logic                        busy;
  logic [15:0]                 drop_count;

  modport master (
    output req_valid, req_field, clear, out_ready,
    input  out_valid, out_field, out_tag, overflow, busy, drop_count
  );

  modport slave (
    input  req_valid, req_field, clear, out_ready,
    output out_valid, out_field, out_tag, overflow, busy, drop_count
  );
endinterface

// File: rtl/field_arbiter.sv
// field_arbiter
//   Captures header fields from N_REQ requesters into one holding slot each and
//   forwards them round-robin through a single registered output word.
//   Optional drop counter: define FIELD_ARB_DROP_CNT_EN to enable a saturating
//   16-bit count of dropped strobes; otherwise drop_count is tied to zero.
// Ports
//   i_sys_clk : clock, all state on rising edge
//   i_reset   : asynchronous active-high reset
//   bus       : field_arbiter_if slave modport (requests, output word, status)
//
// Output FSM
//   state | meaning
//   EMPTY | output register holds no word
//   FULL  | out_valid=1, word waits for out_ready
module field_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIELD_SIZE = 16
) (
  input logic            i_sys_clk,
  input logic            i_reset,
  field_arbiter_if.slave bus
);
  localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FIELD_SIZE-1:0] r_slot [N_REQ];
  logic [N_REQ-1:0]      r_pend;
  logic [N_REQ-1:0]      r_overflow;
  logic [TAG_W-1:0]      r_last;
  logic [FIELD_SIZE-1:0] r_out_field;
  logic [TAG_W-1:0]      r_out_tag;

  logic                  w_out_valid;
  logic                  w_can_grant;
  logic                  w_found;
  logic                  w_grant;
  logic [TAG_W:0]        w_cand;
  logic [TAG_W-1:0]      w_gnt_idx;
  logic [N_REQ-1:0]      w_gnt_onehot;
  logic [N_REQ-1:0]      w_drop;

  assign w_out_valid = (r_state == FULL);
  assign w_can_grant = !w_out_valid || bus.out_ready;

  // Round-robin search from r_last+1; w_cand is one bit wider so a single
  // subtraction wraps it back into range.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = {1'b0, r_last} + (TAG_W+1)'(k);
      if (w_cand >= (TAG_W+1)'(N_REQ))
        w_cand = w_cand - (TAG_W+1)'(N_REQ);
      if (!w_found && r_pend[w_cand[TAG_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[TAG_W-1:0];
      end
    end
  end

  // clear suppresses the grant so the flush cannot race with a pending slot
  assign w_grant      = w_can_grant && w_found && !bus.clear;
  assign w_gnt_onehot = w_grant ? (N_REQ'(1) << w_gnt_idx) : '0;
  // a strobe is only lost when its slot is still pending and not leaving now;
  // strobes in the clear cycle start the new packet and are always kept
  assign w_drop       = bus.req_valid & r_pend & ~w_gnt_onehot & {N_REQ{~bus.clear}};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_grant) w_state_nxt = FULL;
      FULL:  if (bus.out_ready && !w_grant) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= EMPTY;
      r_out_field <= '0;
      r_out_tag   <= '0;
      r_last      <= TAG_W'(N_REQ-1);
      r_overflow  <= '0;
      r_pend      <= '0;
      for (int i = 0; i < N_REQ; i++) r_slot[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_overflow <= w_drop;
      if (w_grant) begin
        r_out_field <= r_slot[w_gnt_idx];
        r_out_tag   <= w_gnt_idx;
        r_last      <= w_gnt_idx;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_valid[i] && !w_drop[i]) begin
          r_slot[i] <= bus.req_field[i*FIELD_SIZE +: FIELD_SIZE];
          r_pend[i] <= 1'b1;
        end else if (bus.clear || w_gnt_onehot[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

`ifdef FIELD_ARB_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic [4:0]  w_drop_pop;
  logic [16:0] w_drop_sum;

  always_comb begin
    w_drop_pop = '0;
    for (int i = 0; i < N_REQ; i++) w_drop_pop = w_drop_pop + 5'(w_drop[i]);
    w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_pop);
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) r_drop_cnt <= '0;
    else         r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  assign bus.drop_count = r_drop_cnt;
`else
  assign bus.drop_count = 16'h0000;
`endif

  assign bus.out_valid = w_out_valid;
  assign bus.out_field = r_out_field;
  assign bus.out_tag   = r_out_tag;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = (|r_pend) | w_out_valid;
endmodule

// File: tb/tb_field_arbiter.sv
module tb_field_arbiter;
  localparam int N = 4;
  localparam int FS = 16;
`ifdef FIELD_ARB_DROP_CNT_EN
  localparam int EXP_DROP = 1;
`else
  localparam int EXP_DROP = 0;
`endif

  typedef struct packed {
    logic [1:0]  tag;
    logic [15:0] field;
  } exp_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  field_arbiter_if #(.N_REQ(N), .FIELD_SIZE(FS)) bus ();

  field_arbiter #(.N_REQ(N), .FIELD_SIZE(FS)) dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] v);
    bus.req_valid[i] = 1'b1;
    bus.req_field[i*FS +: FS] = v;
  endtask

  task automatic push(input logic [1:0] t, input logic [15:0] f);
    exp_t e;
    e.tag = t;
    e.field = f;
    sb.push_back(e);
  endtask

  // scoreboard: every accepted word must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      chk("sb_word_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_tag", 32'(bus.out_tag), 32'(e.tag));
        chk("sb_field", 32'(bus.out_field), 32'(e.field));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_field = '0;
    bus.clear = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    tick();
    chk("rst_out_field", 32'(bus.out_field), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_drop", 32'(bus.drop_count), 32'd0);
    rst = 1'b0;
    tick();

    // all four requesters at once: tags 0..3 on consecutive cycles
    for (int i = 0; i < N; i++) begin
      set_req(i, 16'(i));
      push(2'(i), 16'(i));
    end
    tick();
    bus.req_valid = '0;
    chk("sim_t1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    for (int i = 0; i < N; i++) begin
      chk("sim_valid", 32'(bus.out_valid), 32'd1);
      chk("sim_tag", 32'(bus.out_tag), 32'(i));
      tick();
    end
    chk("sim_done_valid", 32'(bus.out_valid), 32'd0);

    // single request, minimum latency
    set_req(1, 16'hBEEF);
    push(2'd1, 16'hBEEF);
    tick();
    bus.req_valid = '0;
    chk("single_t1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("single_t2_valid", 32'(bus.out_valid), 32'd1);
    chk("single_field", 32'(bus.out_field), 32'hBEEF);
    chk("single_tag", 32'(bus.out_tag), 32'd1);
    tick();
    chk("single_t3_valid", 32'(bus.out_valid), 32'd0);

    // back-pressure: word must hold while out_ready=0
    bus.out_ready = 1'b0;
    set_req(2, 16'h1234);
    push(2'd2, 16'h1234);
    tick();
    bus.req_valid = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_field", 32'(bus.out_field), 32'h1234);
      chk("bp_tag", 32'(bus.out_tag), 32'd2);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_after_valid", 32'(bus.out_valid), 32'd0);

    // overflow on requester 3 while output stalled
    bus.out_ready = 1'b0;
    set_req(0, 16'h5555);
    push(2'd0, 16'h5555);
    tick();
    bus.req_valid = '0;
    tick();
    chk("ov_stalled_valid", 32'(bus.out_valid), 32'd1);
    set_req(3, 16'hAAAA);
    push(2'd3, 16'hAAAA);
    tick();
    set_req(3, 16'hBBBB);
    chk("ov_none_yet", 32'(bus.overflow), 32'd0);
    tick();
    bus.req_valid = '0;
    chk("ov_pulse", 32'(bus.overflow), 32'h8);
    chk("ov_drop_count", 32'(bus.drop_count), 32'(EXP_DROP));
    chk("ov_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("ov_pulse_end", 32'(bus.overflow), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("ov_drain_valid", 32'(bus.out_valid), 32'd0);
    chk("ov_drain_busy", 32'(bus.busy), 32'd0);

    // clear flushes slots 0/1 but keeps the strobe arriving with it
    bus.out_ready = 1'b0;
    set_req(3, 16'h3333);
    push(2'd3, 16'h3333);
    tick();
    bus.req_valid = '0;
    tick();
    set_req(0, 16'h0A0A);
    set_req(1, 16'h0B0B);
    tick();
    bus.req_valid = '0;
    bus.clear = 1'b1;
    set_req(2, 16'h0C0C);
    push(2'd2, 16'h0C0C);
    tick();
    bus.clear = 1'b0;
    bus.req_valid = '0;
    chk("clr_overflow", 32'(bus.overflow), 32'd0);
    chk("clr_busy", 32'(bus.busy), 32'd1);
    chk("clr_hold_field", 32'(bus.out_field), 32'h3333);
    bus.out_ready = 1'b1;
    tick();
    chk("clr_word_field", 32'(bus.out_field), 32'h0C0C);
    chk("clr_word_tag", 32'(bus.out_tag), 32'd2);
    tick();
    chk("clr_end_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_end_busy", 32'(bus.busy), 32'd0);

    // reset while stalled: asynchronous clear, priority back to requester 0
    bus.out_ready = 1'b0;
    set_req(1, 16'h7777);
    tick();
    bus.req_valid = '0;
    tick();
    chk("mr_valid_before", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_field", 32'(bus.out_field), 32'd0);
    chk("mr_tag", 32'(bus.out_tag), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_drop", 32'(bus.drop_count), 32'd0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    set_req(2, 16'h0202);
    set_req(0, 16'h0101);
    push(2'd0, 16'h0101);
    push(2'd2, 16'h0202);
    tick();
    bus.req_valid = '0;
    tick();
    chk("mr_first_tag", 32'(bus.out_tag), 32'd0);
    tick();
    chk("mr_second_tag", 32'(bus.out_tag), 32'd2);
    tick();
    chk("mr_end_valid", 32'(bus.out_valid), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
